// File: rtl/alu_operand_stage.sv
// ID->EX pipeline register in front of the ALU.
// Captures decoded fields, forwards EX/WB results over stale regfile values,
// selects the ALU operands and presents them registered. A load in EX whose
// destination is read by the incoming instruction holds decode for a cycle.
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high; ready never depends on valid, and a presented output payload stays
// stable until out_ready is seen high.
module alu_operand_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int OP_W   = 3,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REG_AW-1:0] rs1_addr,
    input  logic [REG_AW-1:0] rs2_addr,
    input  logic [XLEN-1:0]   rs1_data,
    input  logic [XLEN-1:0]   rs2_data,
    input  logic              rs1_used,
    input  logic              rs2_used,
    input  logic [XLEN-1:0]   pc,
    input  logic [XLEN-1:0]   imm,
    input  logic              use_pc_a,
    input  logic              use_imm_b,
    input  logic [OP_W-1:0]   op_in,
    input  logic              mod_in,
    input  logic [REG_AW-1:0] rd_addr,
    input  logic              rd_we,
    input  logic [REG_AW-1:0] ex_rd_addr,
    input  logic              ex_rd_we,
    input  logic              ex_is_load,
    input  logic [XLEN-1:0]   ex_result,
    input  logic [REG_AW-1:0] wb_rd_addr,
    input  logic              wb_rd_we,
    input  logic [XLEN-1:0]   wb_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   alu_a,
    output logic [XLEN-1:0]   alu_b,
    output logic [OP_W-1:0]   alu_op,
    output logic              alu_mod,
    output logic [REG_AW-1:0] out_rd_addr,
    output logic              out_rd_we,
    output logic [XLEN-1:0]   out_store_data,
    output logic [CNT_W-1:0]  stall_count
);

    logic              r_out_valid;
    logic [XLEN-1:0]   r_alu_a;
    logic [XLEN-1:0]   r_alu_b;
    logic [OP_W-1:0]   r_alu_op;
    logic              r_alu_mod;
    logic [REG_AW-1:0] r_rd_addr;
    logic              r_rd_we;
    logic [XLEN-1:0]   r_store_data;
    logic [CNT_W-1:0]  r_stall_count;

    logic [XLEN-1:0]   w_fwd_rs1;
    logic [XLEN-1:0]   w_fwd_rs2;
    logic              w_hazard;
    logic              w_in_ready;
    logic              w_capture;
    logic              w_cnt_max;

    // Operand bypass: a non-load EX result is newest, then WB, then the regfile.
    // x0 is hardwired zero, so it is never bypassed.
    always_comb begin
        w_fwd_rs1 = rs1_data;
        w_fwd_rs2 = rs2_data;
        if (rs1_addr != '0 && ex_rd_we && ex_rd_addr == rs1_addr && !ex_is_load) begin
            w_fwd_rs1 = ex_result;
        end else if (rs1_addr != '0 && wb_rd_we && wb_rd_addr == rs1_addr) begin
            w_fwd_rs1 = wb_result;
        end
        if (rs2_addr != '0 && ex_rd_we && ex_rd_addr == rs2_addr && !ex_is_load) begin
            w_fwd_rs2 = ex_result;
        end else if (rs2_addr != '0 && wb_rd_we && wb_rd_addr == rs2_addr) begin
            w_fwd_rs2 = wb_result;
        end
    end

    // Load data is not available until WB, so a dependent instruction must wait.
    assign w_hazard = ex_is_load && ex_rd_we && (ex_rd_addr != '0) &&
                      ((rs1_used && rs1_addr == ex_rd_addr) ||
                       (rs2_used && rs2_addr == ex_rd_addr));

    assign w_in_ready = !flush && !w_hazard && (!r_out_valid || out_ready);
    assign w_capture  = in_valid && w_in_ready;
    assign w_cnt_max  = (r_stall_count == {CNT_W{1'b1}});

    // Output register: capture, drain, or drop on flush; payload moves only on capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid  <= 1'b0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_op     <= '0;
            r_alu_mod    <= 1'b0;
            r_rd_addr    <= '0;
            r_rd_we      <= 1'b0;
            r_store_data <= '0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_capture) begin
            r_out_valid  <= 1'b1;
            r_alu_a      <= use_pc_a ? pc : w_fwd_rs1;
            r_alu_b      <= use_imm_b ? imm : w_fwd_rs2;
            r_alu_op     <= op_in;
            r_alu_mod    <= mod_in;
            r_rd_addr    <= rd_addr;
            r_rd_we      <= rd_we;
            r_store_data <= w_fwd_rs2;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Perf counter of load-use stall cycles; sticks at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_count <= '0;
        end else if (in_valid && w_hazard && !flush && !w_cnt_max) begin
            r_stall_count <= r_stall_count + 1'b1;
        end
    end

    assign in_ready       = w_in_ready;
    assign out_valid      = r_out_valid;
    assign alu_a          = r_alu_a;
    assign alu_b          = r_alu_b;
    assign alu_op         = r_alu_op;
    assign alu_mod        = r_alu_mod;
    assign out_rd_addr    = r_rd_addr;
    assign out_rd_we      = r_rd_we;
    assign out_store_data = r_store_data;
    assign stall_count    = r_stall_count;

endmodule
